// File: rtl/mod10_counter_pkg.sv
// -----------------------------------------------------------------------------
// mod10_counter_pkg
//   Shared constants, types and helpers for the decade counter.
//   - MOD10_WIDTH / MOD10_MODULUS : default counter width and modulus
//   - count_t                     : default-width count/din type
//   - clamp_load()                : maps an out-of-range load value to 0
// -----------------------------------------------------------------------------
package mod10_counter_pkg;

  localparam int MOD10_WIDTH   = 4;
  localparam int MOD10_MODULUS = 10;

  typedef logic [MOD10_WIDTH-1:0] count_t;

  // Unsigned compare: values MOD10_MODULUS..2**MOD10_WIDTH-1 load as 0.
  function automatic count_t clamp_load(input count_t din);
    return (din < count_t'(MOD10_MODULUS)) ? din : '0;
  endfunction

endpackage

// File: rtl/mod10_counter_next.sv
// -----------------------------------------------------------------------------
// mod10_counter_next
//   Purely combinational next-state logic for the decade counter.
//   Ports:
//     count      in   WIDTH  current registered count
//     load       in   1      parallel-load request (wins over increment)
//     din        in   WIDTH  load value, clamped to 0 when >= MODULUS
//     next_count out  WIDTH  value to register on the next edge
//     wrap       out  1      high when this edge wraps MODULUS-1 -> 0 by increment
// -----------------------------------------------------------------------------
module mod10_counter_next
  import mod10_counter_pkg::*;
#(
  parameter int MODULUS = MOD10_MODULUS,
  parameter int WIDTH   = MOD10_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] load_value;
  logic [WIDTH:0]   count_inc;
  logic             inc_msb_unused;

  generate
    if (MODULUS == MOD10_MODULUS && WIDTH == MOD10_WIDTH) begin : g_pkg_clamp
      assign load_value = clamp_load(din);
    end else begin : g_generic_clamp
      localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
      assign load_value = ({1'b0, din} < MOD_EXT) ? din : '0;
    end
  endgenerate

  // One extra bit so the sum can never wrap silently; the top bit is never
  // needed because the terminal compare below catches MODULUS-1 first.
  assign count_inc      = {1'b0, count} + (WIDTH+1)'(1);
  assign inc_msb_unused = count_inc[WIDTH];

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    next_count = count_inc[WIDTH-1:0];
    wrap       = 1'b0;
    if (load) begin
      next_count = load_value;
    end else if (count == TERMINAL) begin
      next_count = '0;
      wrap       = 1'b1;
    end
  end

endmodule

// File: rtl/mod10_counter.sv
// -----------------------------------------------------------------------------
// mod10_counter
//   Loadable decade (modulo-MODULUS) up-counter. Counts 0..MODULUS-1, wraps,
//   and accepts a synchronous parallel load; out-of-range loads clamp to 0.
//   Optional feature macro: MOD10_COUNTER_CARRY_EN adds a registered carry_out.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst        in   1      asynchronous active-high reset (count -> 0)
//     load       in   1      synchronous parallel load, priority over increment
//     din        in   WIDTH  load value
//     count      out  WIDTH  registered count, always < MODULUS
//     carry_out  out  1      (MOD10_COUNTER_CARRY_EN only) one-cycle pulse on
//                            the edge where count wraps MODULUS-1 -> 0
// -----------------------------------------------------------------------------
module mod10_counter
  import mod10_counter_pkg::*;
#(
  parameter int MODULUS = MOD10_MODULUS,
  parameter int WIDTH   = MOD10_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count
`ifdef MOD10_COUNTER_CARRY_EN
  ,
  output logic             carry_out
`endif
);

  logic [WIDTH-1:0] next_count;
  logic             wrap;

  mod10_counter_next #(
    .MODULUS(MODULUS),
    .WIDTH  (WIDTH)
  ) u_next (
    .count     (count),
    .load      (load),
    .din       (din),
    .next_count(next_count),
    .wrap      (wrap)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= next_count;
    end
  end

`ifdef MOD10_COUNTER_CARRY_EN
  // wrap is already suppressed by load, so a load at the terminal count or a
  // load of 0 never pulses carry_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_out <= 1'b0;
    end else begin
      carry_out <= wrap;
    end
  end
`else
  logic wrap_unused;
  assign wrap_unused = wrap;
`endif

endmodule

// File: tb/tb_mod10_counter.sv
// -----------------------------------------------------------------------------
// tb_mod10_counter
//   Self-checking bench for mod10_counter: directed vector table, hand-written
//   asynchronous-reset sequences, and a randomised run against a small model.
//   Carry checks are compiled in when MOD10_COUNTER_CARRY_EN is defined.
// -----------------------------------------------------------------------------
module tb_mod10_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] din;
  logic [3:0] count;
`ifdef MOD10_COUNTER_CARRY_EN
  logic       carry_out;
`endif

  int errors = 0;
  int checks = 0;

  mod10_counter dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .din      (din),
    .count    (count)
`ifdef MOD10_COUNTER_CARRY_EN
    ,
    .carry_out(carry_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       load;
    logic [3:0] din;
    logic [3:0] exp_count;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_carry(input string name, input logic expected);
`ifdef MOD10_COUNTER_CARRY_EN
    check(name, int'(carry_out), int'(expected));
`else
    if (expected === 1'bx) $display("unreachable %s", name);
`endif
  endtask

  function automatic void add(input logic l, input logic [3:0] d,
                              input logic [3:0] c, input logic cy);
    vec_t v;
    v.load = l; v.din = d; v.exp_count = c; v.exp_carry = cy;
    vecs.push_back(v);
  endfunction

  int unsigned model_count;
  logic        model_carry;

  initial begin
    // Directed table: each row is applied before one rising edge and the
    // expected values are checked just after it.
    for (int i = 1; i <= 13; i++)                  // 1..9, 0, 1, 2, 3
      add(1'b0, 4'd0, 4'(i % 10), (i == 10));
    add(1'b1, 4'd7, 4'd7, 1'b0);                   // load 7
    add(1'b0, 4'd0, 4'd8, 1'b0);
    add(1'b0, 4'd0, 4'd9, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b1);                   // wrap 9 -> 0
    add(1'b1, 4'd10, 4'd0, 1'b0);                  // clamped loads
    add(1'b1, 4'd12, 4'd0, 1'b0);
    add(1'b1, 4'd15, 4'd0, 1'b0);
    add(1'b1, 4'd9, 4'd9, 1'b0);                   // largest legal load
    add(1'b1, 4'd4, 4'd4, 1'b0);                   // load at 9 wins, no carry
    add(1'b1, 4'd0, 4'd0, 1'b0);                   // load of 0, no carry
    add(1'b0, 4'd0, 4'd1, 1'b0);

    // Reset held 20 ns with a load request present: it must be ignored.
    rst  = 1'b1;
    load = 1'b1;
    din  = 4'd5;
    #20;
    check("reset_hold_count", int'(count), 0);
    check_carry("reset_hold_carry", 1'b0);
    @(posedge clk); #1;
    check("reset_ignores_load", int'(count), 0);

    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      load = vecs[i].load;
      din  = vecs[i].din;
      @(posedge clk); #1;
      check($sformatf("vec%0d_count", i), int'(count), int'(vecs[i].exp_count));
      check_carry($sformatf("vec%0d_carry", i), vecs[i].exp_carry);
      @(negedge clk);
    end

    // Asynchronous reset pulsed mid-cycle: count must clear with no edge.
    load = 1'b0;
    @(posedge clk); #1;
    check("pre_async_count", int'(count), 2);
    #2 rst = 1'b1;
    #1;
    check("async_reset_count", int'(count), 0);
    check_carry("async_reset_carry", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_async_release", int'(count), 1);

    // Drive to 9, then assert reset right after the edge that would have
    // produced the carry: both outputs must clear immediately.
    @(negedge clk);
    load = 1'b1; din = 4'd9;
    @(posedge clk); #1;
    check("load9_before_reset", int'(count), 9);
    @(negedge clk);
    load = 1'b0;
    @(posedge clk); #1;
    check("wrap_before_reset", int'(count), 0);
    check_carry("wrap_carry_before_reset", 1'b1);
    rst = 1'b1;
    #1;
    check_carry("carry_cleared_by_reset", 1'b0);
    @(negedge clk);

    // Randomised run against a reference model.
    model_count = 0;
    model_carry = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst  = ($urandom_range(0, 19) == 0);
      load = ($urandom_range(0, 3) == 0);
      din  = 4'($urandom_range(0, 15));
      #1;
      if (rst) begin
        model_count = 0;
        model_carry = 1'b0;
        check($sformatf("rnd%0d_rst_count", cyc), int'(count), 0);
      end
      @(posedge clk);
      if (!rst) begin
        if (load) begin
          model_count = (din < 4'd10) ? int'(din) : 0;
          model_carry = 1'b0;
        end else if (model_count == 9) begin
          model_count = 0;
          model_carry = 1'b1;
        end else begin
          model_count = model_count + 1;
          model_carry = 1'b0;
        end
      end
      #1;
      check($sformatf("rnd%0d_range", cyc), int'(count < 4'd10), 1);
      check($sformatf("rnd%0d_count", cyc), int'(count), int'(model_count));
      check_carry($sformatf("rnd%0d_carry", cyc), model_carry);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
